// File: rtl/mem_access_stage_if.sv
// Bundle between the MEM stage and its neighbours: EX-side inputs, WB/IF-side outputs.
interface mem_access_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic [6:0]      opcode;
  logic            we;
  logic            re;
  logic [XLEN-1:0] reg_b;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] read_data;
  logic [XLEN-1:0] lmd;
  logic [XLEN-1:0] condpc;
  logic            pc_src;

  // Upstream side: supplies EX results, consumes memory data and next PC.
  modport master (
    output alu_result, zero, opcode, we, re, reg_b, npc,
    input  read_data, lmd, condpc, pc_src
  );

  // MEM stage side.
  modport slave (
    input  alu_result, zero, opcode, we, re, reg_b, npc,
    output read_data, lmd, condpc, pc_src
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of a 5-stage RV32I pipeline: word-addressed data memory with a
// registered load path (lmd) and combinational next-PC selection.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int XLEN        = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_stage_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [XLEN-1:0] mem_r [DEPTH_WORDS];
  logic [XLEN-1:0] lmd_r;
  logic [AW-1:0]   idx_s;
  logic [XLEN-1:0] condpc_s;
  logic            pc_src_s;
  logic            load_s;

  // Byte offset and bits above the memory size are deliberately dropped:
  // accesses are whole words and addresses wrap.
  assign idx_s  = bus.alu_result[2 +: AW];
  assign load_s = bus.re && (bus.opcode == OP_LOAD);

  logic unused_addr_s;
  assign unused_addr_s = &{1'b0, bus.alu_result[1:0], bus.alu_result[XLEN-1:AW+2]};

  // Data memory and load register; the load samples the word before any same-edge store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
      lmd_r <= {XLEN{1'b0}};
    end else begin
      if (bus.we) begin
        mem_r[idx_s] <= bus.reg_b;
      end
      if (load_s) begin
        lmd_r <= mem_r[idx_s];
      end
    end
  end

  // Next-PC select: taken branches and both jumps redirect to the EX target.
  always_comb begin
    condpc_s = bus.npc;
    pc_src_s = 1'b0;
    case (bus.opcode)
      OP_BRANCH: begin
        if (bus.zero) begin
          condpc_s = bus.alu_result;
          pc_src_s = 1'b1;
        end else begin
          condpc_s = bus.npc;
          pc_src_s = 1'b0;
        end
      end
      OP_JAL, OP_JALR: begin
        condpc_s = bus.alu_result;
        pc_src_s = 1'b1;
      end
      default: begin
        condpc_s = bus.npc;
        pc_src_s = 1'b0;
      end
    endcase
  end

  assign bus.read_data = mem_r[idx_s];
  assign bus.lmd       = lmd_r;
  assign bus.condpc    = condpc_s;
  assign bus.pc_src    = pc_src_s;
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a reference model pushes expected
// values into a scoreboard queue as each cycle is driven; observed outputs pop them.
module tb_mem_access_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 256;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] ALUOP  = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage_if #(.XLEN(XLEN)) bus ();

  mem_access_stage #(.DEPTH_WORDS(DEPTH), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] lmd_mdl;
  int          errors = 0;
  int          checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got %08h expected queued value", obs);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  // One pipeline cycle: drive, check combinational outputs, clock, check lmd.
  task automatic step(input logic r, input logic w, input logic rd, input logic [6:0] op,
                      input logic [31:0] addr, input logic [31:0] b, input logic z,
                      input logic [31:0] np);
    logic [7:0]  idx;
    logic        taken;
    @(negedge clk);
    rst            = r;
    bus.we         = w;
    bus.re         = rd;
    bus.opcode     = op;
    bus.alu_result = addr;
    bus.reg_b      = b;
    bus.zero       = z;
    bus.npc        = np;
    #2;
    idx   = addr[9:2];
    taken = (op == JAL) || (op == JALR) || ((op == BRANCH) && z);
    push_exp("read_data", mdl[idx]);
    push_exp("condpc", taken ? addr : np);
    push_exp("pc_src", {31'd0, taken});
    pop_check(bus.read_data);
    pop_check(bus.condpc);
    pop_check({31'd0, bus.pc_src});
    if (r) begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
      lmd_mdl = 32'd0;
    end else begin
      if (rd && (op == LOAD)) lmd_mdl = mdl[idx];
      if (w) mdl[idx] = b;
    end
    push_exp("lmd", lmd_mdl);
    @(posedge clk);
    #1;
    pop_check(bus.lmd);
  endtask

  initial begin
    logic [6:0]  ops [6];
    logic [31:0] a;
    ops[0] = LOAD; ops[1] = STORE; ops[2] = BRANCH;
    ops[3] = JAL;  ops[4] = JALR;  ops[5] = ALUOP;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'hxxxx_xxxx;
    lmd_mdl        = 32'hxxxx_xxxx;
    bus.we         = 1'b0;
    bus.re         = 1'b0;
    bus.opcode     = ALUOP;
    bus.alu_result = 32'd0;
    bus.reg_b      = 32'd0;
    bus.zero       = 1'b0;
    bus.npc        = 32'd0;

    // Reset, then memory and lmd read back as zero.
    step(1'b1, 1'b1, 1'b1, LOAD, 32'h4, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, LOAD, 32'h4, 32'h0, 1'b0, 32'h0);
    check_val("rst_rd4", bus.read_data, 32'h0);
    check_val("rst_lmd", bus.lmd, 32'h0);
    step(1'b0, 1'b0, 1'b1, LOAD, 32'h8, 32'h0, 1'b0, 32'h0);

    // Store then load the same word.
    step(1'b0, 1'b1, 1'b0, STORE, 32'h4, 32'hABCD_1234, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, LOAD, 32'h4, 32'h0, 1'b0, 32'h0);
    check_val("t2_lmd", bus.lmd, 32'hABCD_1234);

    // Second word, persistence of the first, and address aliasing.
    step(1'b0, 1'b1, 1'b0, STORE, 32'h8, 32'h8765_4321, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, LOAD, 32'h8, 32'h0, 1'b0, 32'h0);
    check_val("t3_lmd8", bus.lmd, 32'h8765_4321);
    step(1'b0, 1'b0, 1'b1, LOAD, 32'h4 + 32'(4 * DEPTH), 32'h0, 1'b0, 32'h0);
    check_val("t3_alias", bus.lmd, 32'hABCD_1234);
    step(1'b0, 1'b0, 1'b1, STORE, 32'h8, 32'h0, 1'b0, 32'h0);
    check_val("t3_nonload_hold", bus.lmd, 32'hABCD_1234);

    // Branch and jump selection.
    step(1'b0, 1'b0, 1'b0, BRANCH, 32'h100, 32'h0, 1'b1, 32'h200);
    step(1'b0, 1'b0, 1'b0, BRANCH, 32'h100, 32'h0, 1'b0, 32'h200);
    step(1'b0, 1'b0, 1'b0, JAL,    32'h300, 32'h0, 1'b0, 32'h200);
    step(1'b0, 1'b0, 1'b0, JALR,   32'h304, 32'h0, 1'b0, 32'h200);
    step(1'b0, 1'b0, 1'b0, STORE,  32'h300, 32'h0, 1'b1, 32'h200);
    step(1'b1, 1'b0, 1'b0, JAL,    32'h500, 32'h0, 1'b0, 32'h200);

    // Re-establish contents after that reset, then simultaneous store+load.
    step(1'b0, 1'b1, 1'b0, STORE, 32'h4, 32'hABCD_1234, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, LOAD,  32'h4, 32'h1111_1111, 1'b0, 32'h0);
    check_val("t6_old", bus.lmd, 32'hABCD_1234);
    step(1'b0, 1'b0, 1'b0, LOAD,  32'h4, 32'h0, 1'b0, 32'h0);
    check_val("t6_hold", bus.lmd, 32'hABCD_1234);
    check_val("t6_new", bus.read_data, 32'h1111_1111);

    // Random traffic over a small aliased window.
    for (int n = 0; n < 80; n++) begin
      a = $urandom & 32'h0000_0C1F;
      step(($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom),
           ops[$urandom_range(0, 5)], a, $urandom, 1'($urandom), $urandom);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
